gun_fire_scheduler: RTL and testbench
=====================================

Name: gun_fire_scheduler

Overview:
- Shares the single bullet-spawn interface of the projectile engine between two player guns (gun 0 = left cannon, gun 1 = right cannon).
- Per gun: tracks heat, enforces a minimum inter-shot gap, and runs an overheat lockout.
- Grants spawns round-robin over a valid/ready handshake.
- Sits between the switch/key input logic and the bullet spawner; its heat outputs drive the HUD heat bars.

Parameters:
- TICK_CYCLES, 2_500_000: clock cycles per game tick (20 Hz at 50 MHz); must be >= 1.
- FIRE_GAP, 4: ticks a gun waits after a granted shot before it may request again; must be >= 1.
- COOL_TICKS, 8: ticks of non-shooting per 1-step heat decrement; must be >= 1.
- HEAT_MAX, 15: heat saturation and overheat threshold; must be <= 15.
- RESUME_HEAT, 4: heat at or below which an overheated gun is re-enabled; must be < HEAT_MAX.

Ports:
- clock  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous active-low reset.
- start_game  in  1  synchronous clear, same effect as reset.
- shoot  in  2  fire request per gun, level, bit g = gun g.
- spawn_ready  in  1  spawner accepts the current spawn.
- spawn_valid  out  1  spawn request outstanding.
- spawn_gun  out  1  gun index of the outstanding spawn.
- heat0  out  4  gun 0 heat.
- heat1  out  4  gun 1 heat.
- overheated  out  2  per-gun lockout flag.
- tick  out  1  one-cycle game-tick pulse.

Behaviour:
- Reset (resetn=0, async) or start_game=1 (sync, highest priority):
  - spawn_valid=0, spawn_gun=0, heat=0, overheated=0, tick=0.
  - Gun states = READY; tick counter = TICK_CYCLES-1.
  - Cool counters = COOL_TICKS; rr pointer = 1, so gun 0 wins the first tie.
  - start_game drops spawn_valid without a handshake.
- Tick: down-counter; tick=1 for exactly the cycle the counter is 0, then it reloads to TICK_CYCLES-1.
- Per-gun FSM:
  - READY: pending = shoot[g].
  - GAP: gap counter loaded with FIRE_GAP on grant; decrements on each tick; moves to READY on the tick it reaches 0.
  - OVERHEAT: overheated[g]=1; moves to READY in the cycle heat <= RESUME_HEAT.
- Arbiter (only while spawn_valid=0):
  - Candidates are pending guns in READY.
  - If both are pending, grant the gun != rr pointer.
  - A grant sets spawn_valid=1 and spawn_gun=g on the next clock edge, so spawn_valid is registered 1 cycle after shoot is sampled.
  - The rr pointer is updated to g at grant time.
- Handshake:
  - spawn_valid and spawn_gun hold until a cycle with spawn_valid & spawn_ready.
  - Dropping shoot after a grant does not cancel the spawn.
  - The other gun's requests wait.
- On handshake for gun g (same edge):
  - spawn_valid=0.
  - heat_g = min(heat_g+1, HEAT_MAX).
  - If the new heat == HEAT_MAX, go to OVERHEAT; otherwise go to GAP with gap=FIRE_GAP.
  - The next grant occurs no earlier than the cycle after the handshake.
- Cooling:
  - On each tick where shoot[g]=0 or gun g is in OVERHEAT, cool_g decrements.
  - When cool_g reaches 0: heat_g = max(heat_g-1, 0), and cool_g reloads to COOL_TICKS.
  - A tick with shoot[g]=1 and the gun not in OVERHEAT reloads cool_g to COOL_TICKS.
- Simultaneous increment and decrement on the same edge: heat is unchanged, and cool_g reloads.
- Heat never wraps: 15+1 stays 15, 0-1 stays 0.

Optional Feature:
- Macro: GUN_OVERHEAT_LOCKOUT_EN.
- Defined: OVERHEAT behaves as above, with hysteresis down to RESUME_HEAT.
- Undefined:
  - No OVERHEAT state and RESUME_HEAT is unused.
  - A gun with heat == HEAT_MAX is simply not a candidate.
  - overheated[g] = (heat_g == HEAT_MAX).
  - Cooling applies only when shoot[g]=0, and firing resumes as soon as heat drops to HEAT_MAX-1.

Test Plan (TICK_CYCLES=4, FIRE_GAP=2, COOL_TICKS=3, HEAT_MAX=15, RESUME_HEAT=4):
- Reset then idle 20 cycles -> tick pulses every 4 cycles, spawn_valid=0, heat0=heat1=0, overheated=00.
- shoot=01, spawn_ready=1 -> spawn_valid rises 1 cycle later with spawn_gun=0; handshake gives heat0=1; no new spawn until 2 ticks have elapsed.
- shoot=11, spawn_ready=1 held -> grants alternate 0,1,0,1; heat0 and heat1 each increment once per grant.
- spawn_ready=0 for 10 cycles with shoot=01 then shoot=00 -> spawn_valid and spawn_gun=0 stay stable; heat0 increments only on the cycle spawn_ready=1.
- Gun 0 fired 15 times -> heat0=15, overheated=01, shoot[0] ignored. With shoot=00, heat0 drops 1 per 3 ticks; overheated[0] clears at heat0=4 (33 ticks after entry). Without the macro, it clears at heat0=14.
- start_game pulsed while spawn_valid=1 and heat1=7 -> next cycle spawn_valid=0, heat1=0, overheated=00, tick counter restarts.

Source files
------------

// File: rtl/gun_fire_scheduler.sv
// gun_fire_scheduler
// Shares the single bullet-spawn port between two guns (0 = left, 1 = right).
// Each gun has its own heat, shot-gap and cooling logic. Spawn requests are
// granted round-robin over a valid/ready handshake.
// Optional build macro: GUN_OVERHEAT_LOCKOUT_EN
//   defined   : a gun reaching HEAT_MAX enters an OVERHEAT lockout until heat
//               falls to RESUME_HEAT. Heat keeps cooling while it is locked out.
//   undefined : a gun at HEAT_MAX is simply not a candidate. overheated mirrors
//               heat == HEAT_MAX.
//
// state       | meaning
// ST_READY    | gun may request; pending = shoot
// ST_GAP      | post-shot wait of FIRE_GAP ticks
// ST_OVERHEAT | lockout until heat <= RESUME_HEAT (macro builds only)
module gun_fire_scheduler #(
  parameter int unsigned TICK_CYCLES = 2_500_000,
  parameter int unsigned FIRE_GAP    = 4,
  parameter int unsigned COOL_TICKS  = 8,
  parameter int unsigned HEAT_MAX    = 15,
  parameter int unsigned RESUME_HEAT = 4
) (
  input  logic       clock_i,
  input  logic       resetn_i,
  input  logic       start_game_i,
  input  logic [1:0] shoot_i,
  input  logic       spawn_ready_i,
  output logic       spawn_valid_o,
  output logic       spawn_gun_o,
  output logic [3:0] heat0_o,
  output logic [3:0] heat1_o,
  output logic [1:0] overheated_o,
  output logic       tick_o
);

  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned GW = $clog2(FIRE_GAP + 1);
  localparam int unsigned CW = $clog2(COOL_TICKS + 1);

  localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_CYCLES - 1);
  localparam logic [GW-1:0] GAP_RELOAD  = GW'(FIRE_GAP);
  localparam logic [CW-1:0] COOL_RELOAD = CW'(COOL_TICKS);
  localparam logic [3:0]    HMAX        = 4'(HEAT_MAX);

  // Reject parameter sets the counters and 4-bit heat cannot represent.
  if (TICK_CYCLES < 1 || FIRE_GAP < 1 || COOL_TICKS < 1 ||
      HEAT_MAX > 15 || RESUME_HEAT >= HEAT_MAX) begin : g_bad_params
    $error("gun_fire_scheduler: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_READY    = 2'd0,
    ST_GAP      = 2'd1,
    ST_OVERHEAT = 2'd2
  } gun_state_e;

  gun_state_e      state_q [2];
  gun_state_e      state_d [2];
  logic [GW-1:0]   gap_q   [2];
  logic [GW-1:0]   gap_d   [2];
  logic [CW-1:0]   cool_q  [2];
  logic [CW-1:0]   cool_d  [2];
  logic [3:0]      heat_q  [2];
  logic [3:0]      heat_d  [2];
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            spawn_valid_q, spawn_valid_d;
  logic            spawn_gun_q, spawn_gun_d;
  logic            rr_q, rr_d;

  logic            tick;
  logic            handshake;
  logic            grant_any;
  logic            grant_gun;
  logic [1:0]      cand;
  logic [1:0]      inc;
  logic [1:0]      dec;
  logic [1:0]      cool_en;
  logic [1:0]      overheated;

  // State register: everything clocked, async active-low reset.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      tick_cnt_q    <= TICK_RELOAD;
      spawn_valid_q <= 1'b0;
      spawn_gun_q   <= 1'b0;
      rr_q          <= 1'b1;
      for (int g = 0; g < 2; g++) begin
        state_q[g] <= ST_READY;
        gap_q[g]   <= '0;
        cool_q[g]  <= COOL_RELOAD;
        heat_q[g]  <= '0;
      end
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      spawn_valid_q <= spawn_valid_d;
      spawn_gun_q   <= spawn_gun_d;
      rr_q          <= rr_d;
      for (int g = 0; g < 2; g++) begin
        state_q[g] <= state_d[g];
        gap_q[g]   <= gap_d[g];
        cool_q[g]  <= cool_d[g];
        heat_q[g]  <= heat_d[g];
      end
    end
  end

  // Next state: tick timer, arbiter, handshake, heat/cooling and per-gun FSMs.
  always_comb begin
    tick_cnt_d = tick ? TICK_RELOAD : tick_cnt_q - TW'(1);

    handshake = spawn_valid_q & spawn_ready_i;

    for (int g = 0; g < 2; g++) begin
`ifdef GUN_OVERHEAT_LOCKOUT_EN
      cand[g]    = (state_q[g] == ST_READY) & shoot_i[g];
      cool_en[g] = tick & (~shoot_i[g] | (state_q[g] == ST_OVERHEAT));
`else
      cand[g]    = (state_q[g] == ST_READY) & shoot_i[g] & (heat_q[g] != HMAX);
      cool_en[g] = tick & ~shoot_i[g];
`endif
    end

    // With both pending, the gun that did not win last time gets the grant.
    grant_any = ~spawn_valid_q & (|cand);
    grant_gun = (cand == 2'b11) ? ~rr_q : cand[1];

    spawn_valid_d = spawn_valid_q;
    spawn_gun_d   = spawn_gun_q;
    rr_d          = rr_q;
    if (handshake) begin
      spawn_valid_d = 1'b0;
    end else if (grant_any) begin
      spawn_valid_d = 1'b1;
      spawn_gun_d   = grant_gun;
      rr_d          = grant_gun;
    end

    for (int g = 0; g < 2; g++) begin
      inc[g]    = handshake & (spawn_gun_q == 1'(g));
      dec[g]    = 1'b0;
      cool_d[g] = cool_q[g];
      if (cool_en[g]) begin
        if (cool_q[g] <= CW'(1)) begin
          dec[g]    = 1'b1;
          cool_d[g] = COOL_RELOAD;
        end else begin
          cool_d[g] = cool_q[g] - CW'(1);
        end
      end else if (tick) begin
        cool_d[g] = COOL_RELOAD;
      end

      // A shot landing on the same edge as a cooling step cancels out.
      heat_d[g] = heat_q[g];
      if (inc[g] && !dec[g]) begin
        heat_d[g] = (heat_q[g] >= HMAX) ? HMAX : heat_q[g] + 4'd1;
      end else if (dec[g] && !inc[g]) begin
        heat_d[g] = (heat_q[g] == 4'd0) ? 4'd0 : heat_q[g] - 4'd1;
      end

      state_d[g] = state_q[g];
      gap_d[g]   = gap_q[g];
      case (state_q[g])
        ST_READY: begin
          if (inc[g]) begin
`ifdef GUN_OVERHEAT_LOCKOUT_EN
            if (heat_d[g] == HMAX) begin
              state_d[g] = ST_OVERHEAT;
            end else begin
              state_d[g] = ST_GAP;
              gap_d[g]   = GAP_RELOAD;
            end
`else
            state_d[g] = ST_GAP;
            gap_d[g]   = GAP_RELOAD;
`endif
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (gap_q[g] <= GW'(1)) begin
              gap_d[g]   = '0;
              state_d[g] = ST_READY;
            end else begin
              gap_d[g] = gap_q[g] - GW'(1);
            end
          end
        end
`ifdef GUN_OVERHEAT_LOCKOUT_EN
        ST_OVERHEAT: begin
          if (heat_q[g] <= 4'(RESUME_HEAT)) begin
            state_d[g] = ST_READY;
          end
        end
`endif
        default: begin
          state_d[g] = ST_READY;
        end
      endcase
    end

    // start_game behaves like reset, and drops any spawn without a handshake.
    if (start_game_i) begin
      tick_cnt_d    = TICK_RELOAD;
      spawn_valid_d = 1'b0;
      spawn_gun_d   = 1'b0;
      rr_d          = 1'b1;
      for (int g = 0; g < 2; g++) begin
        state_d[g] = ST_READY;
        gap_d[g]   = '0;
        cool_d[g]  = COOL_RELOAD;
        heat_d[g]  = '0;
      end
    end
  end

  // Outputs: tick pulse and lockout flags decoded from registered state.
  always_comb begin
    tick = (tick_cnt_q == '0);
    for (int g = 0; g < 2; g++) begin
`ifdef GUN_OVERHEAT_LOCKOUT_EN
      overheated[g] = (state_q[g] == ST_OVERHEAT);
`else
      overheated[g] = (heat_q[g] == HMAX);
`endif
    end
  end

  assign spawn_valid_o = spawn_valid_q;
  assign spawn_gun_o   = spawn_gun_q;
  assign heat0_o       = heat_q[0];
  assign heat1_o       = heat_q[1];
  assign overheated_o  = overheated;
  assign tick_o        = tick;

endmodule

// File: tb/tb_gun_fire_scheduler.sv
// Directed bench for gun_fire_scheduler with small timing parameters.
// Expected values are hand-derived from the cycle count since the last
// reset/start_game (ncyc). Lockout expectations follow GUN_OVERHEAT_LOCKOUT_EN.
module tb_gun_fire_scheduler;

  localparam int TC = 4;
  localparam int FG = 2;
  localparam int CT = 3;
  localparam int HM = 15;
  localparam int RH = 4;

  logic       clock = 1'b0;
  logic       resetn;
  logic       start_game;
  logic [1:0] shoot;
  logic       spawn_ready;
  logic       spawn_valid;
  logic       spawn_gun;
  logic [3:0] heat0;
  logic [3:0] heat1;
  logic [1:0] overheated;
  logic       tick;

  int n_checks = 0;
  int n_errors = 0;
  int ncyc     = 0;

  always #5 clock = ~clock;

  gun_fire_scheduler #(
    .TICK_CYCLES(TC),
    .FIRE_GAP   (FG),
    .COOL_TICKS (CT),
    .HEAT_MAX   (HM),
    .RESUME_HEAT(RH)
  ) dut (
    .clock_i      (clock),
    .resetn_i     (resetn),
    .start_game_i (start_game),
    .shoot_i      (shoot),
    .spawn_ready_i(spawn_ready),
    .spawn_valid_o(spawn_valid),
    .spawn_gun_o  (spawn_gun),
    .heat0_o      (heat0),
    .heat1_o      (heat1),
    .overheated_o (overheated),
    .tick_o       (tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (ncyc=%0d)", tag, got, exp, ncyc);
    end
  endtask

  // One clock; sample 1 time unit after the edge and check the tick pulse.
  task automatic cyc();
    logic st;
    st = start_game;
    @(posedge clock);
    #1;
    if (st) ncyc = 0;
    else    ncyc = ncyc + 1;
    check("tick", 32'(tick), (ncyc % TC == TC - 1) ? 1 : 0);
  endtask

  task automatic pulse_start();
    start_game = 1'b1;
    cyc();
    start_game = 1'b0;
  endtask

  initial begin
    logic t;
    bit   found;
    int   ncool;
    int   exp_h;
    int   exp_oh;

    resetn      = 1'b0;
    start_game  = 1'b0;
    shoot       = 2'b00;
    spawn_ready = 1'b0;
    #22;
    check("rst_valid", 32'(spawn_valid), 0);
    check("rst_gun", 32'(spawn_gun), 0);
    check("rst_heat0", 32'(heat0), 0);
    check("rst_heat1", 32'(heat1), 0);
    check("rst_overheated", 32'(overheated), 0);
    check("rst_tick", 32'(tick), 0);
    resetn = 1'b1;
    ncyc   = 0;

    // Idle: only the tick pulse moves.
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("idle_valid", 32'(spawn_valid), 0);
      check("idle_heat", 32'({heat1, heat0}), 0);
      check("idle_overheated", 32'(overheated), 0);
    end

    // Single gun: one-cycle grant latency, then a two-tick gap.
    pulse_start();
    shoot = 2'b01; spawn_ready = 1'b1;
    cyc();
    check("g0_valid", 32'(spawn_valid), 1);
    check("g0_gun", 32'(spawn_gun), 0);
    check("g0_heat_pre", 32'(heat0), 0);
    cyc();
    check("g0_hs_valid", 32'(spawn_valid), 0);
    check("g0_hs_heat", 32'(heat0), 1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("g0_gap_valid", 32'(spawn_valid), 0);
    end
    cyc();
    check("g0_regrant_valid", 32'(spawn_valid), 1);
    check("g0_regrant_gun", 32'(spawn_gun), 0);
    cyc();
    check("g0_second_heat", 32'(heat0), 2);

    // Both guns held: grants at ncyc 1,3,9,13 alternate 0,1,0,1.
    pulse_start();
    shoot = 2'b11; spawn_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cyc();
      check("rr_valid", 32'(spawn_valid),
            (ncyc == 1 || ncyc == 3 || ncyc == 9 || ncyc == 13) ? 1 : 0);
      if (ncyc == 1 || ncyc == 9)  check("rr_gun", 32'(spawn_gun), 0);
      if (ncyc == 3 || ncyc == 13) check("rr_gun", 32'(spawn_gun), 1);
      check("rr_heat0", 32'(heat0), (ncyc >= 2 ? 1 : 0) + (ncyc >= 10 ? 1 : 0));
      check("rr_heat1", 32'(heat1), (ncyc >= 4 ? 1 : 0) + (ncyc >= 14 ? 1 : 0));
    end

    // Back-pressure: spawn held through ready=0 even after shoot drops.
    pulse_start();
    shoot = 2'b01; spawn_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("bp_valid", 32'(spawn_valid), 1);
      check("bp_gun", 32'(spawn_gun), 0);
      check("bp_heat0", 32'(heat0), 0);
      if (ncyc == 2) shoot = 2'b00;
    end
    spawn_ready = 1'b1;
    cyc();
    check("bp_hs_valid", 32'(spawn_valid), 0);
    check("bp_hs_heat0", 32'(heat0), 1);
    spawn_ready = 1'b0;
    cyc();
    check("bp_cool_heat0", 32'(heat0), 0);

    // Handshake on the same edge as a cooling step leaves heat unchanged.
    pulse_start();
    shoot = 2'b01; spawn_ready = 1'b1;
    cyc(); cyc();
    check("sim_first_heat", 32'(heat0), 1);
    shoot = 2'b00;
    while (ncyc < 10) cyc();
    shoot = 2'b01; spawn_ready = 1'b0;
    cyc();
    check("sim_grant", 32'(spawn_valid), 1);
    shoot = 2'b00; spawn_ready = 1'b1;
    cyc();
    check("sim_hs_valid", 32'(spawn_valid), 0);
    check("sim_heat_same", 32'(heat0), 1);
    spawn_ready = 1'b0;
    while (ncyc < 23) cyc();
    check("sim_heat_before_cool", 32'(heat0), 1);
    cyc();
    check("sim_heat_after_cool", 32'(heat0), 0);

    // Overheat: gun 0 fires 15 times, then cools down.
    pulse_start();
    shoot = 2'b01; spawn_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      cyc();
      if (heat0 == 4'd15) found = 1'b1;
    end
    check("oh_reached", 32'(found), 1);
    check("oh_entry_cycle", 32'(ncyc), 114);
    check("oh_flag_entry", 32'(overheated), 1);
    ncool = 0;
    for (int i = 0; i < 12; i++) begin
      t = tick;
      cyc();
`ifdef GUN_OVERHEAT_LOCKOUT_EN
      if (t) ncool++;
`endif
      check("oh_shoot_ignored", 32'(spawn_valid), 0);
      check("oh_hold_heat0", 32'(heat0), 15 - ncool / 3);
    end
    shoot = 2'b00;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      t = tick;
      cyc();
      check("cool_valid", 32'(spawn_valid), 0);
      if (t) begin
        ncool++;
        exp_h = 15 - ncool / 3;
        check("cool_heat0", 32'(heat0), exp_h);
`ifdef GUN_OVERHEAT_LOCKOUT_EN
        exp_oh = 1;
`else
        exp_oh = (exp_h == 15) ? 1 : 0;
`endif
        check("cool_overheated", 32'(overheated), exp_oh);
        if (ncool == 33) found = 1'b1;
      end
    end
    check("cool_finished", 32'(found), 1);
    check("cool_resume_heat", 32'(heat0), RH);
    cyc();
    check("cool_flag_cleared", 32'(overheated), 0);

    // start_game while a gun-1 spawn is outstanding with heat1 = 7.
    pulse_start();
    shoot = 2'b10; spawn_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc();
      if (heat1 == 4'd7) found = 1'b1;
    end
    check("sg_heat_reached", 32'(found), 1);
    spawn_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (spawn_valid) found = 1'b1;
    end
    check("sg_valid_reached", 32'(found), 1);
    check("sg_pre_gun", 32'(spawn_gun), 1);
    check("sg_pre_heat1", 32'(heat1), 7);
    shoot = 2'b00;
    pulse_start();
    check("sg_valid", 32'(spawn_valid), 0);
    check("sg_gun", 32'(spawn_gun), 0);
    check("sg_heat1", 32'(heat1), 0);
    check("sg_overheated", 32'(overheated), 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("sg_after_valid", 32'(spawn_valid), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
